// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD SS.hh up/down timing datapath with programmable preset and sticky done flag
module stopwatch_counter #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        resetButton,
    input  logic        reset_i,
    input  logic        cnt_i,
    input  logic        mode_i,
    input  logic        load_i,
    input  logic [15:0] preset_digits_i,
    output logic [15:0] digits_o,
    output logic        tick_o,
    output logic        done_o
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    logic [PW-1:0] prescale_q, prescale_d;
    logic [15:0]   preset_q, preset_d, digits_q, digits_d;
    logic          done_q, done_d, tick_q, tick_d;
    logic [15:0]   up_v, dn_v, nxt, term;
    logic          run, wrap, step, at_end, carry, borrow, preset_ok;
    always_comb begin
        up_v = digits_q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_v[4*i +: 4] = !carry ? digits_q[4*i +: 4] :
                             digits_q[4*i +: 4] == 4'd9 ? 4'd0 : digits_q[4*i +: 4] + 4'd1;
            carry = carry && digits_q[4*i +: 4] == 4'd9;
        end
    end
    // a borrow out of sec tens only happens from 00.00, which the terminal guard blocks
    always_comb begin
        dn_v = digits_q;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dn_v[4*i +: 4] = !borrow ? digits_q[4*i +: 4] :
                             digits_q[4*i +: 4] == 4'd0 ? 4'd9 : digits_q[4*i +: 4] - 4'd1;
            borrow = borrow && digits_q[4*i +: 4] == 4'd0;
        end
    end
    always_comb begin
        run        = cnt_i && !done_q;
        wrap       = run && prescale_q == PS_MAX;
        step       = wrap && !reset_i;
        term       = mode_i ? 16'h0000 : 16'h5999;
        at_end     = digits_q == term;
        nxt        = mode_i ? dn_v : up_v;
        preset_ok  = preset_digits_i[15:12] <= 4'd5 && preset_digits_i[11:8] <= 4'd9 &&
                     preset_digits_i[7:4] <= 4'd9 && preset_digits_i[3:0] <= 4'd9;
        prescale_d = reset_i || wrap ? '0 : run ? prescale_q + 1'b1 : prescale_q;
        digits_d   = reset_i ? (mode_i ? preset_q : 16'h0000) : step && !at_end ? nxt : digits_q;
        done_d     = reset_i ? 1'b0 : step ? at_end || nxt == term : done_q;
        preset_d   = !reset_i && load_i && !cnt_i && preset_ok ? preset_digits_i : preset_q;
        tick_d     = step;
    end
    always_ff @(posedge clk or posedge resetButton) begin
        if (resetButton) begin
            prescale_q <= '0;
            preset_q   <= 16'h3000;
            digits_q   <= 16'h0000;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            preset_q   <= preset_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
        end
    end
    assign digits_o = digits_q;
    assign tick_o   = tick_q;
    assign done_o   = done_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed stimulus against a hundredths-of-a-second reference model
module tb_stopwatch_counter;
    localparam int TD = 4;
    logic        clk = 1'b0;
    logic        resetButton, reset, cnt, mode, load;
    logic [15:0] pd;
    logic [15:0] digits;
    logic        tick, done;
    int          pass_cnt = 0, tot_cnt = 0;
    int          m_val, m_pre, m_ps;
    bit          m_done, m_tick;
    int          nt, bad;

    stopwatch_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .resetButton(resetButton), .reset_i(reset), .cnt_i(cnt),
        .mode_i(mode), .load_i(load), .preset_digits_i(pd),
        .digits_o(digits), .tick_o(tick), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(logic [15:0] b);
        return b[15:12] <= 5 && b[11:8] <= 9 && b[7:4] <= 9 && b[3:0] <= 9;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: value kept as hundredths of a second, 0..5999
    always @(posedge clk or posedge resetButton) begin
        if (resetButton) begin
            m_val = 0; m_pre = 3000; m_ps = 0; m_done = 0; m_tick = 0;
        end else if (reset) begin
            m_ps = 0; m_done = 0; m_tick = 0;
            m_val = mode ? m_pre : 0;
        end else begin
            m_tick = 0;
            if (load && !cnt && bcd_ok(pd)) m_pre = from_bcd(pd);
            if (cnt && !m_done) begin
                m_ps++;
                if (m_ps == TD) begin
                    m_ps = 0;
                    m_tick = 1;
                    if (!mode) begin
                        if (m_val < 5999) m_val++;
                        if (m_val == 5999) m_done = 1;
                    end else begin
                        if (m_val > 0) m_val--;
                        if (m_val == 0) m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_digits", 32'(digits), 32'(to_bcd(m_val)));
        chk("model_tick", 32'(tick), 32'(m_tick));
        chk("model_done", 32'(done), 32'(m_done));
    end

    initial begin
        resetButton = 1; reset = 0; cnt = 0; mode = 0; load = 0; pd = 16'h0;
        #3;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        @(negedge clk); resetButton = 0; reset = 1;
        @(negedge clk); reset = 0; cnt = 1;
        nt = 0; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nt += int'(tick);
            bad += int'(tick != (k % 4 == 0));
        end
        chk("up40_digits", 32'(digits), 32'h0010);
        chk("up40_ticks", 32'(nt), 32'd10);
        chk("up40_spacing", 32'(bad), 32'd0);
        chk("up40_done", 32'(done), 32'h0);
        repeat (989 * TD) @(negedge clk);
        chk("up_0999", 32'(digits), 32'h0999);
        repeat (TD) @(negedge clk);
        chk("up_1000", 32'(digits), 32'h1000);
        repeat (4999 * TD) @(negedge clk);
        chk("up_5999", 32'(digits), 32'h5999);
        chk("up_done", 32'(done), 32'h1);
        nt = 0;
        repeat (20) begin @(negedge clk); nt += int'(tick); end
        chk("up_hold_digits", 32'(digits), 32'h5999);
        chk("up_hold_ticks", 32'(nt), 32'd0);
        cnt = 0; mode = 1; pd = 16'h0003; load = 1;
        @(negedge clk); load = 0; reset = 1;
        @(negedge clk); reset = 0;
        chk("dn_start", 32'(digits), 32'h0003);
        chk("dn_done_clr", 32'(done), 32'h0);
        cnt = 1;
        repeat (TD) @(negedge clk);
        chk("dn_0002", 32'(digits), 32'h0002);
        repeat (TD) @(negedge clk);
        chk("dn_0001", 32'(digits), 32'h0001);
        chk("dn_0001_done", 32'(done), 32'h0);
        repeat (TD) @(negedge clk);
        chk("dn_0000", 32'(digits), 32'h0000);
        chk("dn_done", 32'(done), 32'h1);
        repeat (20) @(negedge clk);
        chk("dn_hold", 32'(digits), 32'h0000);
        cnt = 0; mode = 0; reset = 1;
        @(negedge clk); reset = 0; cnt = 1;
        repeat (6) @(negedge clk);
        chk("pause_pre", 32'(digits), 32'h0001);
        cnt = 0;
        repeat (50) @(negedge clk);
        chk("pause_hold", 32'(digits), 32'h0001);
        cnt = 1;
        @(negedge clk);
        chk("pause_tick1", 32'(tick), 32'h0);
        @(negedge clk);
        chk("pause_tick2", 32'(tick), 32'h1);
        chk("pause_digits", 32'(digits), 32'h0002);
        cnt = 0; mode = 1; reset = 1;
        @(negedge clk); reset = 0; cnt = 1;
        repeat (14) @(negedge clk);
        chk("rb_pre_done", 32'(done), 32'h1);
        #2 resetButton = 1;
        #1;
        chk("rb_digits", 32'(digits), 32'h0);
        chk("rb_done", 32'(done), 32'h0);
        chk("rb_tick", 32'(tick), 32'h0);
        @(negedge clk); resetButton = 0;
        bad = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bad += int'(tick != (k == 4));
        end
        chk("rb_prescale0", 32'(bad), 32'd0);
        cnt = 0; reset = 1;
        @(negedge clk); reset = 0;
        chk("rb_preset", 32'(digits), 32'h3000);
        pd = 16'h6A00; load = 1;
        @(negedge clk); load = 0; reset = 1;
        @(negedge clk); reset = 0;
        chk("ld_invalid", 32'(digits), 32'h3000);
        cnt = 1; pd = 16'h1234; load = 1;
        @(negedge clk); load = 0; cnt = 0; reset = 1;
        @(negedge clk); reset = 0;
        chk("ld_while_cnt", 32'(digits), 32'h3000);
        load = 1;
        @(negedge clk); load = 0; reset = 1;
        @(negedge clk); reset = 0;
        chk("ld_valid", 32'(digits), 32'h1234);
        reset = 1; load = 1; pd = 16'h0500;
        @(negedge clk); load = 0;
        @(negedge clk); reset = 0;
        chk("ld_with_reset", 32'(digits), 32'h1234);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timing datapath for the programmable stopwatch/timer. It consumes the `reset` and `cnt` levels driven by the stopwatch control FSM and keeps four BCD digits in SS.hh format, counting up or down from a programmable preset. It raises `done` at the terminal value and feeds the display driver.

## Interface

Parameters:
- `TICK_DIV`, default 1_000_000: clk cycles per 10 ms step (100 MHz clk); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `resetButton`  in  1  asynchronous, active-high reset.
- `reset`  in  1  synchronous clear/reload level from the control FSM.
- `cnt`  in  1  count-enable level from the control FSM.
- `mode`  in  1  0 = count up (stopwatch), 1 = count down (timer).
- `load`  in  1  single-cycle strobe; captures `presetDigits` into the preset register.
- `presetDigits`  in  16  BCD {sec tens, sec ones, hund tens, hund ones}.
- `digits`  out  16  current BCD value, same packing.
- `tick`  out  1  one-cycle pulse on every digit step.
- `done`  out  1  sticky terminal-value flag.

## Operation

- Registers:
  - `prescale`, 0..TICK_DIV-1.
  - `preset[15:0]`.
  - `digits[15:0]`.
  - `done`.
- Async reset (`resetButton`=1): `prescale`=0, `preset`=16'h3000 (30.00), `digits`=16'h0000, `done`=0, `tick`=0.
- Priority per clock edge: resetButton > `reset` > `load` > count step.
- `reset`=1 (level):
  - `prescale`←0, `done`←0, `tick`=0.
  - `digits`←`preset` if `mode`=1, else 16'h0000.
  - Reloads every cycle while held.
- `load`=1 with `reset`=0:
  - Accepted only when `cnt`=0 and `presetDigits` is valid BCD (each nibble ≤9, sec-tens nibble ≤5).
  - Invalid value or `cnt`=1: strobe ignored, `preset` unchanged.
  - An accepted load does not alter `digits`; the next `reset` applies it.
- Prescaler:
  - Advances only when `cnt`=1 and `done`=0.
  - Holds its value when `cnt`=0, so a pause preserves the sub-step fraction.
  - Wraps TICK_DIV-1 → 0 and generates a step in that same cycle.
- Step, up mode (`mode`=0):
  - BCD increment: hund ones 9→0 carries, hund tens 9→0 carries, sec ones 9→0 carries, sec tens 0..5.
  - 59.98→59.99 sets `done`; no further steps.
- Step, down mode (`mode`=1):
  - BCD decrement with borrows; sec tens floor 0, hund/sec ones 0→9.
  - 00.01→00.00 sets `done`.
  - If `digits`=00.00 when the step arrives, no change and `done`←1.
- `done` handling:
  - Sticky; cleared only by `reset` or `resetButton`.
  - While `done`=1, prescaler and digits freeze regardless of `cnt`.
- `mode` change mid-count takes effect on the next step and does not clear `done`.
- `digits` never holds an invalid BCD value.

## Timing

- Steps occur every TICK_DIV cycles of `cnt`=1 time.
- Output latency:
  - `digits` and `done` are registered and update on the edge at which `prescale` wraps.
  - `tick` is registered and high for exactly that cycle after the edge.
- `cnt` rising: the first step occurs TICK_DIV - `prescale` cycles later.
- `cnt` falling in the same cycle as a would-be wrap: no step; prescale holds at TICK_DIV-1.
- `reset` and step in the same cycle: `reset` wins; no `tick`.
- `load` coincident with `reset`: `reset` executes; `load` is dropped.
- `resetButton` mid-operation: immediate asynchronous clear, independent of clk.

## Test plan

- TICK_DIV=4, async reset, then `reset`=1 for 1 cycle with `mode`=0, `cnt`=1 held for 40 cycles → `digits`=16'h0010, 10 `tick` pulses spaced 4 cycles apart, `done`=0.
- Up-mode carry: preset `digits` to 09.99 via a count run, one more step → 10.00. Continue to 59.99 → `done`=1, digits hold 59.99 for 20 extra cycles, no `tick`.
- Down mode: `load` 16'h0003 with `cnt`=0, then `reset`, then count → `digits` 00.03→00.02→00.01→00.00. `done`=1 on the 00.00 step; further `cnt` gives no change.
- Invalid load: `presetDigits`=16'h6A00 → `preset` stays 30.00. `load` with `cnt`=1 → ignored. After `reset` in `mode`=1, `digits`=16'h3000.
- Pause: run `cnt` for 6 cycles (`prescale`=2 after one step), drop `cnt` for 50 cycles, reassert → next `tick` exactly 2 cycles after reassertion.
- `resetButton` pulse mid-count with `done`=1 → same-cycle `digits`=0, `done`=0, `preset`=16'h3000, `prescale`=0.
